axil_cfg_arbiter: RTL

Shares the single AXI4-Lite configuration slave port of `Garnet` (`axi4_slave_*`) between `NUM_REQ` independent register-access requesters, e.g. the test driver and a host loader. It sits between the requesters and the `axil_ifc` bundle. Each accepted request becomes exactly one complete AXI4-Lite read or write. The response returns only to the requester that issued it. Arbitration is round-robin, and only one transaction is outstanding at a time.

---
 rtl/axil_cfg_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/axil_cfg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axil_cfg_arbiter
// Brief    : Round-robin arbiter sharing one AXI4-Lite config slave among
//            NUM_REQ requesters, one outstanding transaction at a time.
// Revision : 1.0
// ============================================================================
module axil_cfg_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic [ADDR_WIDTH-1:0]         awaddr,
    output logic                          awvalid,
    input  logic                          awready,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic                          wvalid,
    input  logic                          wready,
    input  logic [1:0]                    bresp,
    input  logic                          bvalid,
    output logic                          bready,
    output logic [ADDR_WIDTH-1:0]         araddr,
    output logic                          arvalid,
    input  logic                          arready,
    input  logic [DATA_WIDTH-1:0]         rdata,
    input  logic [1:0]                    rresp,
    input  logic                          rvalid,
    output logic                          rready
);

    localparam int c_IDX_W = $clog2(NUM_REQ);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_WR_REQ  = 3'd1;
    localparam logic [2:0] c_WR_RESP = 3'd2;
    localparam logic [2:0] c_RD_REQ  = 3'd3;
    localparam logic [2:0] c_RD_RESP = 3'd4;
    localparam logic [2:0] c_DONE    = 3'd5;

    logic [2:0]            r_state;
    logic [c_IDX_W-1:0]    r_rr_ptr;
    logic [c_IDX_W-1:0]    r_owner;
    logic                  r_aw_done;
    logic                  r_w_done;

    logic                  w_gnt_found;
    logic [c_IDX_W-1:0]    w_gnt_idx;
    logic [c_IDX_W-1:0]    w_sel;
    logic [c_IDX_W-1:0]    w_ptr_next;
    logic                  w_accept;
    logic                  w_sel_write;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic                  w_aw_fire;
    logic                  w_w_fire;

    // Scan downwards from the farthest offset so the nearest valid index at or after rr_ptr wins.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_sel       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sel = c_IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (req_valid[w_sel]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_sel;
            end
        end
    end

    always_comb begin
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_idx == c_IDX_W'(i)) begin
                w_sel_write = req_write[i];
                w_sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_accept   = !reset && (r_state == c_IDLE) && w_gnt_found;
    assign w_ptr_next = (w_gnt_idx == c_IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    assign w_aw_fire  = awvalid && awready;
    assign w_w_fire   = wvalid && wready;

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_rr_ptr  <= '0;
            r_owner   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            awaddr    <= '0;
            awvalid   <= 1'b0;
            wdata     <= '0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            araddr    <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_owner  <= w_gnt_idx;
                        r_rr_ptr <= w_ptr_next;
                        if (w_sel_write) begin
                            awaddr  <= w_sel_addr;
                            wdata   <= w_sel_wdata;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            r_state <= c_WR_REQ;
                        end else begin
                            araddr  <= w_sel_addr;
                            arvalid <= 1'b1;
                            r_state <= c_RD_REQ;
                        end
                    end
                end
                c_WR_REQ: begin
                    if (w_aw_fire) begin
                        awvalid   <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_fire) begin
                        wvalid   <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    // AW and W may complete in the same cycle or in either order.
                    if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        bready    <= 1'b1;
                        r_state   <= c_WR_RESP;
                    end
                end
                c_WR_RESP: begin
                    if (bvalid) begin
                        bready             <= 1'b0;
                        rsp_valid[r_owner] <= 1'b1;
                        rsp_rdata          <= '0;
                        rsp_err            <= (bresp != 2'b00);
                        r_state            <= c_DONE;
                    end
                end
                c_RD_REQ: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        r_state <= c_RD_RESP;
                    end
                end
                c_RD_RESP: begin
                    if (rvalid) begin
                        rready             <= 1'b0;
                        rsp_valid[r_owner] <= 1'b1;
                        rsp_rdata          <= rdata;
                        rsp_err            <= (rresp != 2'b00);
                        r_state            <= c_DONE;
                    end
                end
                c_DONE: begin
                    rsp_valid <= '0;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                    r_state   <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
